// File: rtl/dmem_run_ctrl.sv
// Run sequencer and data-memory arbiter: the host owns dataMem while the core is held,
// the core owns it while running, and the run ends on core_done or a watchdog timeout.
module dmem_run_ctrl #(
    parameter int              AW         = 8,
    parameter int              DW         = 8,
    parameter int              CW         = 16,
    parameter logic [CW-1:0]   MAX_CYCLES = 16'd4095
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic          core_run,
    input  logic          core_done,
    input  logic          core_mem_we,
    input  logic [AW-1:0] core_mem_addr,
    input  logic [DW-1:0] core_mem_wdata,
    output logic [DW-1:0] core_mem_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          run_done,
    output logic          timeout,
    output logic [CW-1:0] cycle_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } stateType;

    stateType      state;
    stateType      stateNext;
    logic          inRun;
    logic [CW-1:0] cycleInc;
    logic          watchdogHit;
    logic          startRun;

    assign inRun       = (state == RUN);
    assign cycleInc    = cycle_count + CW'(1);
    assign watchdogHit = (cycleInc == MAX_CYCLES);
    assign startRun    = start && !inRun;

    assign core_run = inRun;
    assign busy     = inRun;

    // Host and core never share the port: ownership flips purely on the state register.
    assign mem_we         = inRun ? core_mem_we    : (host_req & host_we);
    assign mem_addr       = inRun ? core_mem_addr  : host_addr;
    assign mem_wdata      = inRun ? core_mem_wdata : host_wdata;
    assign core_mem_rdata = mem_rdata;
    assign host_gnt       = host_req & !inRun;

    always_comb begin
        // NOTE: next state defaults to the current state so no path leaves it unassigned (no latch).
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = RUN;
            RUN:     if (core_done || watchdogHit) stateNext = HALT;
            HALT:    if (start) stateNext = RUN;
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
            run_done    <= 1'b0;
            timeout     <= 1'b0;
        end else if (startRun) begin
            cycle_count <= '0;
            run_done    <= 1'b0;
            timeout     <= 1'b0;
        end else if (inRun) begin
            cycle_count <= cycleInc;
            // done takes priority over a watchdog firing on the same edge
            if (core_done) begin
                run_done <= 1'b1;
            end else if (watchdogHit) begin
                timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
        end else begin
            host_rvalid <= host_gnt & !host_we;
            if (host_gnt && !host_we) begin
                host_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_run_ctrl.sv
// Directed bench for dmem_run_ctrl: a default-watchdog instance with a dataMem model,
// plus a MAX_CYCLES=8 instance for the watchdog scenarios.
module tb_dmem_run_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [7:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic       host_gnt;
    logic [7:0] host_rdata;
    logic       host_rvalid;
    logic       core_run;
    logic       core_done = 1'b0;
    logic       core_mem_we = 1'b0;
    logic [7:0] core_mem_addr = '0;
    logic [7:0] core_mem_wdata = '0;
    logic [7:0] core_mem_rdata;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       run_done;
    logic       timeout;
    logic [15:0] cycle_count;

    logic        wdHostGnt, wdHostRvalid, wdCoreRun, wdMemWe, wdBusy, wdRunDone, wdTimeout;
    logic [7:0]  wdHostRdata, wdCoreMemRdata, wdMemAddr, wdMemWdata;
    logic [7:0]  wdMemRdata = 8'h00;
    logic [15:0] wdCycleCount;

    int total = 0;
    int bad = 0;

    logic [7:0] dataMem [256];

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) dataMem[mem_addr] <= mem_wdata;
    assign mem_rdata = dataMem[mem_addr];

    dmem_run_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .core_run(core_run), .core_done(core_done), .core_mem_we(core_mem_we),
        .core_mem_addr(core_mem_addr), .core_mem_wdata(core_mem_wdata), .core_mem_rdata(core_mem_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .run_done(run_done), .timeout(timeout), .cycle_count(cycle_count)
    );

    dmem_run_ctrl #(.MAX_CYCLES(16'd8)) dutWd (
        .clk(clk), .reset(reset), .start(start),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(wdHostGnt), .host_rdata(wdHostRdata), .host_rvalid(wdHostRvalid),
        .core_run(wdCoreRun), .core_done(core_done), .core_mem_we(core_mem_we),
        .core_mem_addr(core_mem_addr), .core_mem_wdata(core_mem_wdata), .core_mem_rdata(wdCoreMemRdata),
        .mem_we(wdMemWe), .mem_addr(wdMemAddr), .mem_wdata(wdMemWdata), .mem_rdata(wdMemRdata),
        .busy(wdBusy), .run_done(wdRunDone), .timeout(wdTimeout), .cycle_count(wdCycleCount)
    );

    // Called at a negedge; leaves start low at the negedge after the start edge (first RUN cycle).
    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts RUN cycles of the chosen instance from a negedge; doneAt=0 means never assert core_done.
    task automatic runCycles(input bit useWd, input int doneAt, input int limit, output int n);
        n = 0;
        for (int i = 0; i < limit; i++) begin
            if (!(useWd ? wdCoreRun : core_run)) break;
            n++;
            core_done = (doneAt != 0 && n == doneAt);
            @(negedge clk);
        end
        core_done = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (core_run !== 1'b0) begin bad++; $display("FAIL rst_core_run got=%b exp=0", core_run); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (host_rdata !== 8'h00) begin bad++; $display("FAIL rst_host_rdata got=%h exp=00", host_rdata); end
        total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL rst_host_rvalid got=%b exp=0", host_rvalid); end
        total++; if ({run_done, timeout} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b exp=00", {run_done, timeout}); end
        total++; if (cycle_count !== 16'd0) begin bad++; $display("FAIL rst_cycle_count got=%0d exp=0", cycle_count); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_preload();
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'hA5;
        #1;
        total++; if (host_gnt !== 1'b1) begin bad++; $display("FAIL wr_gnt got=%b exp=1", host_gnt); end
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL wr_mem_we got=%b exp=1", mem_we); end
        total++; if (mem_addr !== 8'h10) begin bad++; $display("FAIL wr_mem_addr got=%h exp=10", mem_addr); end
        @(negedge clk);
        host_we = 1'b0;
        #1;
        total++; if (host_gnt !== 1'b1) begin bad++; $display("FAIL rd_gnt got=%b exp=1", host_gnt); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rd_mem_we got=%b exp=0", mem_we); end
        total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL rd_rvalid_early got=%b exp=0", host_rvalid); end
        @(posedge clk); #1;
        total++; if (host_rvalid !== 1'b1) begin bad++; $display("FAIL rd_rvalid got=%b exp=1", host_rvalid); end
        total++; if (host_rdata !== 8'hA5) begin bad++; $display("FAIL rd_rdata got=%h exp=a5", host_rdata); end
        @(negedge clk);
        host_req = 1'b0;
        @(posedge clk); #1;
        total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL rd_rvalid_pulse got=%b exp=0", host_rvalid); end
        total++; if (host_rdata !== 8'hA5) begin bad++; $display("FAIL rd_rdata_hold got=%h exp=a5", host_rdata); end
    endtask

    task automatic test_normal_run();
        int n;
        pulseStart();
        runCycles(1'b0, 5, 20, n);
        total++; if (n !== 5) begin bad++; $display("FAIL run_len got=%0d exp=5", n); end
        total++; if (cycle_count !== 16'd5) begin bad++; $display("FAIL run_cycle_count got=%0d exp=5", cycle_count); end
        total++; if ({run_done, timeout} !== 2'b10) begin bad++; $display("FAIL run_flags got=%b exp=10", {run_done, timeout}); end
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        #1;
        total++; if (host_gnt !== 1'b1) begin bad++; $display("FAIL run_gnt_back got=%b exp=1", host_gnt); end
        @(negedge clk);
        host_req = 1'b0;
    endtask

    task automatic test_arbitration();
        pulseStart();
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
        core_mem_we = 1'b0; core_mem_addr = 8'h44;
        #1;
        total++; if (host_gnt !== 1'b0) begin bad++; $display("FAIL arb_gnt_run got=%b exp=0", host_gnt); end
        total++; if (mem_addr !== 8'h44) begin bad++; $display("FAIL arb_mem_addr_core got=%h exp=44", mem_addr); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL arb_busy got=%b exp=1", busy); end
        @(negedge clk);
        core_mem_we = 1'b1; core_mem_addr = 8'h20; core_mem_wdata = 8'h3C; core_done = 1'b1;
        #1;
        total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h20, 8'h3C}) begin
            bad++; $display("FAIL arb_core_store got=%b/%h/%h exp=1/20/3c", mem_we, mem_addr, mem_wdata);
        end
        total++; if (host_gnt !== 1'b0) begin bad++; $display("FAIL arb_gnt_run2 got=%b exp=0", host_gnt); end
        total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL arb_rvalid_run got=%b exp=0", host_rvalid); end
        @(negedge clk);
        core_done = 1'b0;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL arb_core_we_ignored got=%b exp=0", mem_we); end
        total++; if (host_gnt !== 1'b1) begin bad++; $display("FAIL arb_gnt_halt got=%b exp=1", host_gnt); end
        total++; if (core_mem_rdata !== 8'h3C) begin bad++; $display("FAIL arb_core_rdata got=%h exp=3c", core_mem_rdata); end
        @(posedge clk); #1;
        total++; if ({host_rvalid, host_rdata} !== {1'b1, 8'h3C}) begin
            bad++; $display("FAIL arb_readback got=%b/%h exp=1/3c", host_rvalid, host_rdata);
        end
        @(negedge clk);
        host_req = 1'b0; core_mem_we = 1'b0;
    endtask

    task automatic test_restart();
        int n;
        pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        runCycles(1'b0, 3, 20, n);
        total++; if (cycle_count !== 16'd4) begin bad++; $display("FAIL rs_start_ignored got=%0d exp=4", cycle_count); end
        total++; if (run_done !== 1'b1) begin bad++; $display("FAIL rs_run_done got=%b exp=1", run_done); end
        start = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'h5A;
        #1;
        total++; if ({host_gnt, mem_we} !== 2'b11) begin bad++; $display("FAIL rs_wr_gnt got=%b exp=11", {host_gnt, mem_we}); end
        @(posedge clk); #1;
        total++; if (core_run !== 1'b1) begin bad++; $display("FAIL rs_core_run got=%b exp=1", core_run); end
        total++; if (cycle_count !== 16'd0) begin bad++; $display("FAIL rs_cycle_clear got=%0d exp=0", cycle_count); end
        total++; if ({run_done, timeout} !== 2'b00) begin bad++; $display("FAIL rs_flags_clear got=%b exp=00", {run_done, timeout}); end
        total++; if (dataMem[8'h30] !== 8'h5A) begin bad++; $display("FAIL rs_write_commit got=%h exp=5a", dataMem[8'h30]); end
        @(negedge clk);
        start = 1'b0; host_req = 1'b0; host_we = 1'b0; core_done = 1'b1;
        @(posedge clk); #1;
        total++; if ({run_done, cycle_count} !== {1'b1, 16'd1}) begin
            bad++; $display("FAIL rs_second_run got=%b/%0d exp=1/1", run_done, cycle_count);
        end
        @(negedge clk);
        core_done = 1'b0;
    endtask

    task automatic test_reset_async();
        bit reached;
        reached = 1'b0;
        pulseStart();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (cycle_count == 16'd37) begin reached = 1'b1; break; end
        end
        total++; if (reached !== 1'b1) begin bad++; $display("FAIL ar_reach37 got=%0d exp=37", cycle_count); end
        #2;
        reset = 1'b0;
        #1;
        total++; if ({core_run, busy} !== 2'b00) begin bad++; $display("FAIL ar_core_run got=%b exp=00", {core_run, busy}); end
        total++; if (cycle_count !== 16'd0) begin bad++; $display("FAIL ar_cycle_count got=%0d exp=0", cycle_count); end
        total++; if ({run_done, timeout} !== 2'b00) begin bad++; $display("FAIL ar_flags got=%b exp=00", {run_done, timeout}); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if ({busy, cycle_count} !== {1'b0, 16'd0}) begin
            bad++; $display("FAIL ar_idle got=%b/%0d exp=0/0", busy, cycle_count);
        end
    endtask

    task automatic test_watchdog();
        int n;
        pulseStart();
        runCycles(1'b1, 0, 20, n);
        total++; if (n !== 8) begin bad++; $display("FAIL wd_len got=%0d exp=8", n); end
        total++; if (wdCycleCount !== 16'd8) begin bad++; $display("FAIL wd_cycle_count got=%0d exp=8", wdCycleCount); end
        total++; if ({wdRunDone, wdTimeout} !== 2'b01) begin bad++; $display("FAIL wd_flags got=%b exp=01", {wdRunDone, wdTimeout}); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wd_default_still_run got=%b exp=1", busy); end
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        pulseStart();
        runCycles(1'b1, 8, 20, n);
        total++; if (n !== 8) begin bad++; $display("FAIL wd_done_len got=%0d exp=8", n); end
        total++; if ({wdRunDone, wdTimeout} !== 2'b10) begin bad++; $display("FAIL wd_done_wins got=%b exp=10", {wdRunDone, wdTimeout}); end
        total++; if (wdCycleCount !== 16'd8) begin bad++; $display("FAIL wd_done_count got=%0d exp=8", wdCycleCount); end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_normal_run();
        test_arbitration();
        test_restart();
        test_reset_async();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_run_ctrl.md
Name: dmem_run_ctrl

Overview:
- Run sequencer and data-memory arbiter for the 8-bit core.
- Holds the core stalled while a host preloads dataMem, then releases the core and hands it the memory port.
- Detects core `done` or a watchdog timeout, then returns the memory port to the host for result readback.
- Sits between the host/testbench port, the core's dataMem interface and dataMem itself.

Parameters:
- AW, 8, data memory address width
- DW, 8, data memory word width
- CW, 16, cycle counter width
- MAX_CYCLES, 16'd4095, watchdog limit in RUN cycles (1 .. 2^CW-1)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- start  in  1  one-cycle request to begin a core run
- host_req  in  1  host memory access request
- host_we  in  1  host write (1) / read (0)
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_gnt  out  1  host access accepted this cycle (combinational)
- host_rdata  out  DW  registered read data
- host_rvalid  out  1  host_rdata valid, one-cycle pulse
- core_run  out  1  1 = core may execute; 0 = core held (drives core reset/stall)
- core_done  in  1  core halt indication
- core_mem_we  in  1  core store enable
- core_mem_addr  in  AW  core address
- core_mem_wdata  in  DW  core store data
- core_mem_rdata  out  DW  memory read data to core
- mem_we  out  1  to dataMem
- mem_addr  out  AW  to dataMem
- mem_wdata  out  DW  to dataMem
- mem_rdata  in  DW  from dataMem (combinational read)
- busy  out  1  state == RUN
- run_done  out  1  sticky: last run ended by core_done
- timeout  out  1  sticky: last run ended by watchdog
- cycle_count  out  CW  RUN cycles of the last/current run

Behaviour:
- Reset (reset==0, async):
  - State = IDLE; core_run = 0.
  - host_rdata = 0, host_rvalid = 0, run_done = 0, timeout = 0, cycle_count = 0.
  - Asserting reset mid-RUN aborts the run; the core is held on the same edge-independent assertion.
- States: IDLE, RUN, HALT. core_run = busy = (state == RUN), decoded from the state register.
- Memory mux:
  - In RUN, mem_* = core_mem_*.
  - Otherwise mem_addr = host_addr, mem_wdata = host_wdata, mem_we = host_req & host_we.
  - core_mem_we is ignored outside RUN.
  - core_mem_rdata = mem_rdata always.
- host_gnt = host_req & (state != RUN). Host requests in RUN are not granted and must be held by the host.
- Host read: on an edge with host_gnt & !host_we, host_rdata <= mem_rdata and host_rvalid <= 1 next cycle; otherwise host_rvalid <= 0. This gives 1-cycle read latency, back-to-back reads allowed. A write completes on the granted edge.
- IDLE:
  - start -> RUN next cycle; on that edge cycle_count <= 0, run_done <= 0, timeout <= 0.
  - core_done is ignored.
- RUN, per edge:
  - cycle_count <= cycle_count + 1.
  - If core_done: -> HALT, run_done <= 1.
  - Else if cycle_count + 1 == MAX_CYCLES: -> HALT, timeout <= 1.
  - start is ignored.
- HALT:
  - Host owns memory; flags and cycle_count hold.
  - start -> RUN with the same clearing as from IDLE.
- Simultaneous events:
  - start with host_req in IDLE/HALT: the host access is granted and completes that cycle; RUN starts next cycle.
  - core_done in the cycle the watchdog would fire: done wins, run_done = 1, timeout = 0.
- cycle_count never wraps; the maximum reachable value is MAX_CYCLES.

Test Plan:
- Reset async: drop reset mid-cycle during RUN with cycle_count=37 -> core_run, busy, cycle_count, flags all 0 immediately; state IDLE after release.
- Preload/readback: in IDLE write 0xA5 to addr 0x10, read 0x10 next cycle -> host_gnt=1 both cycles, mem_we=1 on write only, host_rdata=0xA5 with host_rvalid=1 one cycle after the read grant.
- Normal run: start pulse, core_done asserted on 5th RUN cycle -> core_run high exactly 5 cycles, cycle_count=5, run_done=1, timeout=0, host_gnt returns.
- Arbitration: host_req held (read 0x20) during RUN while core stores 0x3C to 0x20 -> host_gnt=0 in RUN, mem_addr follows core; after HALT, host read returns 0x3C.
- Watchdog: MAX_CYCLES=8, core_done never asserted -> HALT after 8 RUN cycles, cycle_count=8, timeout=1, run_done=0; core_done asserted on 8th cycle instead -> run_done=1, timeout=0.
- Restart/ignore: start in RUN ignored; start in HALT with host_req write -> write committed, flags cleared, new run begins next cycle with cycle_count=0.
